sc_cpu: RTL and testbench



---
 rtl/sc_pkg.sv | 38 +++
 rtl/sc_cpu_if.sv | 21 ++
 rtl/sc_datamem.sv | 64 ++++++
 rtl/sc_cpu.sv | 142 ++++++++++++++
 tb/tb_sc_cpu.sv | 274 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/sc_pkg.sv
// Shared encodings for the single-cycle MIPS-subset computer.
package sc_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_SLL = 6'h00;
  localparam logic [5:0] FN_SRL = 6'h02;
  localparam logic [5:0] FN_SRA = 6'h03;
  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_XOR = 6'h26;

  localparam logic [7:0] IO_IN0  = 8'h80;
  localparam logic [7:0] IO_IN1  = 8'h84;
  localparam logic [7:0] IO_OUT0 = 8'h80;
  localparam logic [7:0] IO_OUT1 = 8'h84;
  localparam logic [7:0] IO_OUT2 = 8'h88;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR,
    ALU_SLL, ALU_SRL, ALU_SRA, ALU_LUI
  } alu_op_t;

endpackage

// File: rtl/sc_cpu_if.sv
// Board-side bundle of the computer: switch inputs, display outputs and debug taps.
interface sc_cpu_if;
  logic [3:0]  in_port0;
  logic [3:0]  in_port1;
  logic [31:0] out_port0;
  logic [31:0] out_port1;
  logic [31:0] out_port2;
  logic [31:0] pc;
  logic [31:0] inst;
  logic [31:0] aluout;
  logic [31:0] memout;

  modport master (
    output in_port0, in_port1,
    input  out_port0, out_port1, out_port2, pc, inst, aluout, memout
  );
  modport slave (
    input  in_port0, in_port1,
    output out_port0, out_port1, out_port2, pc, inst, aluout, memout
  );
endinterface

// File: rtl/sc_datamem.sv
// Data RAM plus memory-mapped I/O; reads combinational, writes land on the commit edge.
module sc_datamem
  import sc_pkg::*;
#(
  parameter int DMEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        commit,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  in_port0,
  input  logic [3:0]  in_port1,
  output logic [31:0] rdata,
  output logic [31:0] out_port0,
  output logic [31:0] out_port1,
  output logic [31:0] out_port2
);
  localparam int DAW = $clog2(DMEM_WORDS);

  logic [31:0] ram [DMEM_WORDS];
  logic        io_sel;
  logic [7:0]  io_addr;
  logic [31:0] io_rdata;
  logic        unused_addr;

  assign io_sel      = addr[7];
  assign io_addr     = {addr[7:2], 2'b00};
  assign unused_addr = ^{addr[31:8], addr[1:0]};

  always_comb begin
    io_rdata = '0;
    case (io_addr)
      IO_IN0:  io_rdata = {28'b0, in_port0};
      IO_IN1:  io_rdata = {28'b0, in_port1};
      default: io_rdata = '0;
    endcase
  end

  assign rdata = io_sel ? io_rdata : ram[addr[DAW+1:2]];

  // RAM is never cleared, but a reset edge still suppresses the store.
  always_ff @(posedge clk) begin
    if (resetn && commit && we && !io_sel)
      ram[addr[DAW+1:2]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_port0 <= '0;
      out_port1 <= '0;
      out_port2 <= '0;
    end else if (commit && we && io_sel) begin
      case (io_addr)
        IO_OUT0: out_port0 <= wdata;
        IO_OUT1: out_port1 <= wdata;
        IO_OUT2: out_port2 <= wdata;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/sc_cpu.sv
// Single-cycle MIPS-subset computer: decode, ALU, register file and ROM inline.
// An instruction commits on every mem_clk edge where phase==1 (CPI of 2).
module sc_cpu
  import sc_pkg::*;
#(
  parameter string IMEM_FILE  = "sc_instmem.hex",
  parameter int    IMEM_WORDS = 64,
  parameter int    DMEM_WORDS = 32
) (
  input logic     mem_clk,
  input logic     resetn,
  sc_cpu_if.slave bus
);
  localparam int IAW = $clog2(IMEM_WORDS);

  logic [31:0] rom  [IMEM_WORDS];
  logic [31:0] regs [32];
  logic        phase;
  logic [31:0] pc, inst, pc4, next_pc;
  logic [31:0] rs_val, rt_val, sext, zext, alu_b, aluout, memout, wb_dat;
  logic [5:0]  op, fn;
  logic [4:0]  rs, rt, rd, sa, dst;
  logic [15:0] imm;
  alu_op_t     alu_op;
  logic        use_imm, zext_imm, reg_we, mem_to_reg, mem_we;
  logic        link, jump, jreg, br_eq, br_ne;

  assign inst   = rom[pc[IAW+1:2]];
  assign op     = inst[31:26];
  assign rs     = inst[25:21];
  assign rt     = inst[20:16];
  assign rd     = inst[15:11];
  assign sa     = inst[10:6];
  assign fn     = inst[5:0];
  assign imm    = inst[15:0];
  assign sext   = {{16{imm[15]}}, imm};
  assign zext   = {16'b0, imm};
  assign pc4    = pc + 32'd4;
  assign rs_val = regs[rs];
  assign rt_val = regs[rt];

  // Unlisted opcodes and functs fall through with every write disabled.
  always_comb begin
    alu_op = ALU_ADD; use_imm = 1'b0; zext_imm = 1'b0; reg_we = 1'b0;
    dst = rd; mem_to_reg = 1'b0; mem_we = 1'b0;
    link = 1'b0; jump = 1'b0; jreg = 1'b0; br_eq = 1'b0; br_ne = 1'b0;
    case (op)
      OP_RTYPE: begin
        reg_we = 1'b1;
        case (fn)
          FN_ADD:  alu_op = ALU_ADD;
          FN_SUB:  alu_op = ALU_SUB;
          FN_AND:  alu_op = ALU_AND;
          FN_OR:   alu_op = ALU_OR;
          FN_XOR:  alu_op = ALU_XOR;
          FN_SLL:  alu_op = ALU_SLL;
          FN_SRL:  alu_op = ALU_SRL;
          FN_SRA:  alu_op = ALU_SRA;
          FN_JR:   begin reg_we = 1'b0; jreg = 1'b1; end
          default: reg_we = 1'b0;
        endcase
      end
      OP_ADDI: begin use_imm = 1'b1; reg_we = 1'b1; dst = rt; end
      OP_ANDI: begin use_imm = 1'b1; zext_imm = 1'b1; alu_op = ALU_AND; reg_we = 1'b1; dst = rt; end
      OP_ORI:  begin use_imm = 1'b1; zext_imm = 1'b1; alu_op = ALU_OR;  reg_we = 1'b1; dst = rt; end
      OP_XORI: begin use_imm = 1'b1; zext_imm = 1'b1; alu_op = ALU_XOR; reg_we = 1'b1; dst = rt; end
      OP_LUI:  begin alu_op = ALU_LUI; reg_we = 1'b1; dst = rt; end
      OP_LW:   begin use_imm = 1'b1; reg_we = 1'b1; dst = rt; mem_to_reg = 1'b1; end
      OP_SW:   begin use_imm = 1'b1; mem_we = 1'b1; end
      OP_BEQ:  br_eq = 1'b1;
      OP_BNE:  br_ne = 1'b1;
      OP_J:    jump = 1'b1;
      OP_JAL:  begin jump = 1'b1; link = 1'b1; reg_we = 1'b1; dst = 5'd31; end
      default: ;
    endcase
  end

  always_comb begin
    alu_b  = use_imm ? (zext_imm ? zext : sext) : rt_val;
    aluout = '0;
    case (alu_op)
      ALU_ADD: aluout = rs_val + alu_b;
      ALU_SUB: aluout = rs_val - alu_b;
      ALU_AND: aluout = rs_val & alu_b;
      ALU_OR:  aluout = rs_val | alu_b;
      ALU_XOR: aluout = rs_val ^ alu_b;
      ALU_SLL: aluout = rt_val << sa;
      ALU_SRL: aluout = rt_val >> sa;
      ALU_SRA: aluout = $signed(rt_val) >>> sa;
      ALU_LUI: aluout = {imm, 16'h0000};
      default: aluout = '0;
    endcase
  end

  always_comb begin
    next_pc = pc4;
    if (jreg)
      next_pc = rs_val;
    else if (jump)
      next_pc = {pc4[31:28], inst[25:0], 2'b00};
    else if ((br_eq && rs_val == rt_val) || (br_ne && rs_val != rt_val))
      next_pc = pc4 + {sext[29:0], 2'b00};
  end

  assign wb_dat = link ? pc4 : (mem_to_reg ? memout : aluout);

  // regs[0] is zeroed by reset and never written, so $0 reads 0 without a mux.
  always_ff @(posedge mem_clk) begin
    if (!resetn) begin
      phase <= 1'b0;
      pc    <= '0;
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else begin
      phase <= ~phase;
      if (phase) begin
        pc <= next_pc;
        if (reg_we && dst != 5'd0) regs[dst] <= wb_dat;
      end
    end
  end

  sc_datamem #(.DMEM_WORDS(DMEM_WORDS)) u_datamem (
    .clk       (mem_clk),
    .resetn    (resetn),
    .commit    (phase),
    .we        (mem_we),
    .addr      (aluout),
    .wdata     (rt_val),
    .in_port0  (bus.in_port0),
    .in_port1  (bus.in_port1),
    .rdata     (memout),
    .out_port0 (bus.out_port0),
    .out_port1 (bus.out_port1),
    .out_port2 (bus.out_port2)
  );

  assign bus.pc     = pc;
  assign bus.inst   = inst;
  assign bus.aluout = aluout;
  assign bus.memout = memout;

endmodule

// File: tb/tb_sc_cpu.sv
// Directed programs loaded into the ROM; expected values queued at load time, popped at each check.
module tb_sc_cpu;
  import sc_pkg::*;

  logic mem_clk;
  logic resetn;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];

  localparam logic [31:0] C_PCS [10] = '{32'd4, 32'd8, 32'd16, 32'd20, 32'd40,
                                         32'd44, 32'd24, 32'd28, 32'd32, 32'd32};

  sc_cpu_if bus();

  sc_cpu #(.IMEM_FILE("")) dut (
    .mem_clk (mem_clk),
    .resetn  (resetn),
    .bus     (bus)
  );

  initial mem_clk = 1'b0;
  always #5 mem_clk = ~mem_clk;

  function automatic logic [31:0] enc_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [4:0] sa,
                                        input logic [5:0] fn);
    return {OP_RTYPE, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] enc_j(input logic [5:0] op, input logic [25:0] tgt);
    return {op, tgt};
  endfunction

  task automatic clear_rom();
    for (int i = 0; i < 64; i++) dut.rom[i] = 32'h0;
  endtask

  task automatic put(input int addr, input logic [31:0] w);
    dut.rom[addr >> 2] = w;
  endtask

  task automatic expect_val(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [31:0] obs);
    logic [31:0] e;
    string       t;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL sb_empty: observed %h required <queued value>", obs);
      return;
    end
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    if (obs !== e) begin
      n_err++;
      $display("FAIL %s: observed %h required %h", t, obs, e);
    end
  endtask

  task automatic step();
    repeat (2) @(posedge mem_clk);
    #1;
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    repeat (3) @(posedge mem_clk);
    #1;
    resetn = 1'b1;
  endtask

  initial begin
    resetn = 1'b0;
    bus.in_port0 = 4'd0;
    bus.in_port1 = 4'd0;

    // Program A: arithmetic, $0 write discard, undefined instructions
    clear_rom();
    put(0,  enc_i(OP_ADDI, 0, 1, 16'd5));
    put(4,  enc_i(OP_ADDI, 0, 2, 16'hFFFD));
    put(8,  enc_r(1, 2, 3, 0, FN_ADD));
    put(12, enc_r(2, 1, 4, 0, FN_SUB));
    put(16, enc_i(OP_SW, 0, 3, 16'h0080));
    put(20, enc_i(OP_SW, 0, 4, 16'h0084));
    put(24, enc_i(OP_ADDI, 0, 0, 16'd7));
    put(28, enc_i(OP_SW, 0, 0, 16'h0080));
    put(32, enc_i(6'h3F, 1, 1, 16'h1234));
    put(36, enc_i(OP_SW, 0, 1, 16'h0088));
    put(40, enc_r(1, 1, 1, 0, 6'h21));
    put(44, enc_i(OP_SW, 0, 1, 16'h0084));

    expect_val("rst_pc", 32'h0);
    expect_val("rst_out0", 32'h0);
    expect_val("rst_out1", 32'h0);
    expect_val("rst_out2", 32'h0);
    do_reset();
    check(bus.pc);
    check(bus.out_port0);
    check(bus.out_port1);
    check(bus.out_port2);

    expect_val("rel_edge1_pc", 32'h0);
    @(posedge mem_clk); #1;
    check(bus.pc);
    expect_val("rel_edge2_pc", 32'h4);
    @(posedge mem_clk); #1;
    check(bus.pc);

    for (int i = 2; i <= 6; i++) begin
      expect_val("A_pc", 32'(i * 4));
      step();
      check(bus.pc);
    end
    expect_val("A_add_out0", 32'h0000_0002);
    expect_val("A_sub_out1", 32'hFFFF_FFF8);
    check(bus.out_port0);
    check(bus.out_port1);

    expect_val("A_r0_out0", 32'h0);
    step(); step();
    check(bus.out_port0);

    expect_val("A_undef_pc", 32'd36);
    expect_val("A_undef_out1", 32'hFFFF_FFF8);
    expect_val("A_undef_out2", 32'h0);
    step();
    check(bus.pc);
    check(bus.out_port1);
    check(bus.out_port2);

    expect_val("A_r1_kept_out2", 32'd5);
    expect_val("A_badfn_out1", 32'd5);
    step();
    check(bus.out_port2);
    step(); step();
    check(bus.out_port1);

    // Program B: RAM and I/O round trip
    clear_rom();
    put(0,  enc_i(OP_LW, 0, 1, 16'h0080));
    put(4,  enc_i(OP_LW, 0, 2, 16'h0084));
    put(8,  enc_r(1, 2, 3, 0, FN_ADD));
    put(12, enc_i(OP_SW, 0, 3, 16'h0008));
    put(16, enc_i(OP_LW, 0, 5, 16'h0008));
    put(20, enc_i(OP_SW, 0, 5, 16'h0088));
    put(24, enc_i(OP_LW, 0, 6, 16'h008C));
    put(28, enc_i(OP_SW, 0, 3, 16'h008C));
    bus.in_port0 = 4'd9;
    bus.in_port1 = 4'd4;

    expect_val("B_in0_memout", 32'd9);
    do_reset();
    check(bus.memout);

    expect_val("B_lw_inst", enc_i(OP_LW, 0, 5, 16'h0008));
    expect_val("B_lw_aluout", 32'd8);
    expect_val("B_ram_memout", 32'd13);
    repeat (4) step();
    check(bus.inst);
    check(bus.aluout);
    check(bus.memout);

    expect_val("B_unmapped_memout", 32'h0);
    expect_val("B_out2", 32'd13);
    step(); step();
    check(bus.memout);
    check(bus.out_port2);

    expect_val("B_ign_out0", 32'h0);
    expect_val("B_ign_out1", 32'h0);
    expect_val("B_ign_out2", 32'd13);
    step(); step();
    check(bus.out_port0);
    check(bus.out_port1);
    check(bus.out_port2);

    // Program C: branches, jal/jr
    clear_rom();
    put(0,  enc_i(OP_ADDI, 0, 1, 16'd1));
    put(4,  enc_i(OP_ADDI, 0, 2, 16'd1));
    put(8,  enc_i(OP_BEQ, 1, 2, 16'd1));
    put(12, enc_i(OP_ADDI, 0, 7, 16'h0055));
    put(16, enc_i(OP_BNE, 1, 2, 16'd5));
    put(20, enc_j(OP_JAL, 26'd10));
    put(24, enc_i(OP_SW, 0, 31, 16'h0080));
    put(28, enc_i(OP_SW, 0, 7, 16'h0084));
    put(32, enc_j(OP_J, 26'd8));
    put(40, enc_i(OP_ADDI, 0, 8, 16'd3));
    put(44, enc_r(31, 0, 0, 0, FN_JR));
    do_reset();
    for (int i = 0; i < 10; i++) begin
      expect_val("C_pc", C_PCS[i]);
      step();
      check(bus.pc);
    end
    expect_val("C_link_out0", 32'd24);
    expect_val("C_skipped_out1", 32'h0);
    check(bus.out_port0);
    check(bus.out_port1);

    // Program D: logic, shifts, lui
    clear_rom();
    put(0,  enc_i(OP_LUI, 0, 1, 16'h8000));
    put(4,  enc_r(0, 1, 2, 4, FN_SRA));
    put(8,  enc_i(OP_ORI, 0, 3, 16'hF0F0));
    put(12, enc_i(OP_XORI, 3, 4, 16'hFFFF));
    put(16, enc_i(OP_SW, 0, 2, 16'h0080));
    put(20, enc_i(OP_SW, 0, 4, 16'h0084));
    put(24, enc_r(0, 1, 5, 4, FN_SRL));
    put(28, enc_i(OP_SW, 0, 5, 16'h0088));
    put(32, enc_r(2, 4, 6, 0, FN_OR));
    put(36, enc_i(OP_ANDI, 6, 7, 16'hFF00));
    put(40, enc_r(6, 2, 8, 0, FN_XOR));
    put(44, enc_r(0, 8, 9, 4, FN_SLL));
    put(48, enc_i(OP_SW, 0, 6, 16'h0080));
    put(52, enc_i(OP_SW, 0, 7, 16'h0084));
    put(56, enc_i(OP_SW, 0, 9, 16'h0088));
    do_reset();

    expect_val("D_sra_out0", 32'hF800_0000);
    expect_val("D_xori_out1", 32'h0000_0F0F);
    expect_val("D_srl_out2", 32'h0800_0000);
    repeat (8) step();
    check(bus.out_port0);
    check(bus.out_port1);
    check(bus.out_port2);

    expect_val("D_pc", 32'd60);
    expect_val("D_or_out0", 32'hF800_0F0F);
    expect_val("D_andi_out1", 32'h0000_0F00);
    expect_val("D_sll_out2", 32'h0000_F0F0);
    repeat (7) step();
    check(bus.pc);
    check(bus.out_port0);
    check(bus.out_port1);
    check(bus.out_port2);

    // Reset landing on a commit edge wins over the commit
    expect_val("rst_commit_pc", 32'h0);
    expect_val("rst_commit_out0", 32'h0);
    @(posedge mem_clk); #1;
    resetn = 1'b0;
    @(posedge mem_clk); #1;
    check(bus.pc);
    check(bus.out_port0);
    resetn = 1'b1;

    expect_val("rst_commit_restart_pc", 32'h4);
    step();
    check(bus.pc);

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL sb_leftover: observed %0d entries required 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
